// File: rtl/rx_pkg.sv
// Shared frame layout constants and FSM state type for the RX packet decoder.
package rx_pkg;

  localparam int unsigned START_IDX  = 0;
  localparam int unsigned DATA_LSB   = 1;
  localparam int unsigned DATA_MSB   = 8;
  localparam int unsigned PARITY_IDX = 9;
  localparam int unsigned STOP_IDX   = 10;
  localparam int unsigned PACKET_W   = 11;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_PUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Show-ahead byte FIFO with registered head/valid/count; a pop frees a slot for a same-cycle write.
module rx_byte_fifo
  import rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              rd_i,
  output logic              accept_c_o,
  output logic [BYTE_W-1:0] head_o,
  output logic              valid_o,
  output logic [CW-1:0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [BYTE_W-1:0] head_q, head_d;
  logic              valid_q;
  logic              full, pop, push;

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    pop        = rd_i && (count_q != '0);
    accept_c_o = !full || pop;
    push       = wr_i && accept_c_o;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    head_d     = '0;
    // A byte written into an otherwise-empty FIFO is the next head; storage is not yet updated.
    if (count_d != '0) begin
      if (push && ((count_q - CW'(pop)) == '0)) head_d = wdata_i;
      else                                      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/rx_packet_decoder.sv
// Decodes 11-bit UART-style frames on a synchronised strobe and queues good bytes.
// Optional feature: define RX_PARITY_CHECK_EN to enable the parity check.
module rx_packet_decoder
  import rx_pkg::*;
#(
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PACKET_W-1:0]         packet,
  input  logic                        packet_completion,
  input  logic                        rd_en,
  output logic [BYTE_W-1:0]           Rx_DATA,
  output logic                        Rx_VALID,
  output logic                        Rx_PERROR,
  output logic                        Rx_FERROR,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  state_t              state_q, state_d;
  logic [2:0]          sync_q;
  logic [PACKET_W-1:0] packet_q, packet_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                ovf_q, ovf_d;
  logic                rise_c, perr_c, ferr_c, push_c, accept_c;

  // Two synchroniser stages plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], packet_completion};
  end

  assign rise_c = sync_q[1] & ~sync_q[2];
  assign ferr_c = (packet_q[START_IDX] != 1'b0) || (packet_q[STOP_IDX] != 1'b1);

`ifdef RX_PARITY_CHECK_EN
  assign perr_c = ((^packet_q[DATA_MSB:DATA_LSB]) ^ packet_q[PARITY_IDX]) != 1'(PARITY_ODD);
`else
  assign perr_c = 1'b0;
  logic unused_parity;
  assign unused_parity = packet_q[PARITY_IDX] ^ 1'(PARITY_ODD);
`endif

  always_comb begin
    state_d  = state_q;
    packet_d = packet_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ovf_d    = ovf_q;
    push_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise_c) begin
          packet_d = packet;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        perr_d  = perr_c;
        ferr_d  = ferr_c;
        state_d = (perr_c || ferr_c) ? ST_IDLE : ST_PUSH;
      end
      ST_PUSH: begin
        push_c  = 1'b1;
        if (!accept_c) ovf_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      packet_q <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      packet_q <= packet_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
    end
  end

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .wr_i       (push_c),
    .wdata_i    (packet_q[DATA_MSB:DATA_LSB]),
    .rd_i       (rd_en),
    .accept_c_o (accept_c),
    .head_o     (Rx_DATA),
    .valid_o    (Rx_VALID),
    .count_o    (fifo_count)
  );

  assign Rx_PERROR = perr_q;
  assign Rx_FERROR = ferr_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/rx_packet_decoder.md
RX_PACKET_DECODER -- requirements
Module: rx_packet_decoder

Interface
REQ-001 SHALL have parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; byte FIFO entries, power of two, 2..16.
REQ-003 SHALL have port clk  in  1  single system clock; all state changes on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port packet  in  11  frame from the upstream receiver: [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
REQ-006 SHALL have port packet_completion  in  1  frame-ready strobe, asynchronous to clk, high for at least 1 clk period.
REQ-007 SHALL have port rd_en  in  1  consumer pop request (display/controller side).
REQ-008 SHALL have port Rx_DATA  out  8  FIFO head byte (show-ahead).
REQ-009 SHALL have port Rx_VALID  out  1  FIFO non-empty.
REQ-010 SHALL have port Rx_PERROR  out  1  last checked frame had a parity error.
REQ-011 SHALL have port Rx_FERROR  out  1  last checked frame had a framing error.
REQ-012 SHALL have port overflow  out  1  sticky: a good frame was dropped because the FIFO was full.
REQ-013 SHALL have port fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL synchronise packet_completion through two flops and detect its rising edge with a third flop.
REQ-015 SHALL implement FSM IDLE -> CHECK -> PUSH -> IDLE, entered from IDLE on a detected rising edge.
REQ-016 SHALL latch packet into an internal register on the IDLE->CHECK transition; packet is required to stay stable for 3 clk after the strobe.
REQ-017 In CHECK, SHALL flag a framing error when start != 0 or stop != 1, and a parity error when XOR(data, parity) != PARITY_ODD.
REQ-018 In CHECK, SHALL register Rx_PERROR and Rx_FERROR; both hold until the next CHECK.
REQ-019 SHALL go from CHECK to PUSH only if both errors are clear; otherwise to IDLE and discard the frame.
REQ-020 In PUSH, SHALL write the data byte to the FIFO if not full; if full, SHALL drop it and set overflow.
REQ-021 Latency: strobe first sampled at edge 0; errors visible after edge 3; Rx_VALID high after edge 4.
REQ-022 SHALL ignore rising edges detected while in CHECK or PUSH.
REQ-023 SHALL pop when rd_en and Rx_VALID; rd_en while empty SHALL be ignored.
REQ-024 Simultaneous pop and PUSH while full SHALL accept both: count unchanged, no overflow.
REQ-025 Simultaneous pop and PUSH while empty SHALL leave count 1 with the new byte at the head.
REQ-026 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.
REQ-027 Rx_DATA SHALL be 8'h00 when the FIFO is empty.

Reset
REQ-028 While reset is low, SHALL force FSM=IDLE, synchroniser flops=0, pointers and fifo_count=0, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, overflow=0, Rx_DATA=8'h00.
REQ-029 Reset asserted mid-frame SHALL discard the frame in progress; no push occurs after release.
REQ-030 A strobe already high at reset release SHALL be detected as a rising edge exactly once.

Configuration
REQ-031 With RX_PARITY_CHECK_EN defined, SHALL perform the parity check per REQ-017.
REQ-032 Without RX_PARITY_CHECK_EN, SHALL ignore the parity bit, tie Rx_PERROR to 0, and PARITY_ODD has no effect.

Structure
REQ-033 Package rx_pkg SHALL hold the frame bit-index constants (START_IDX=0, DATA_LSB=1, DATA_MSB=8, PARITY_IDX=9, STOP_IDX=10), PACKET_W=11, and the FSM state typedef.
REQ-034 SHALL instantiate one sub-module, rx_byte_fifo, containing the storage, pointers, count, and show-ahead logic; the FSM stays in rx_packet_decoder.

Verification
REQ-035 Bench SHALL drive packet=11'h54A (0xA5, even parity OK) with a strobe -> Rx_VALID=1 after edge 4, Rx_DATA=8'hA5, both errors 0, fifo_count=1.
REQ-036 Bench SHALL drive packet=11'h74A with RX_PARITY_CHECK_EN, PARITY_ODD=0 -> Rx_PERROR=1, Rx_FERROR=0, fifo_count unchanged; without the macro -> byte 8'hA5 is pushed.
REQ-037 Bench SHALL drive packet=11'h14A (stop=0) -> Rx_FERROR=1, no push.
REQ-038 Bench SHALL send 5 good frames 8'h01..8'h05 with no reads, FIFO_DEPTH=4 -> fifo_count=4, overflow=1, Rx_DATA=8'h01; then 4 pops yield 01,02,03,04.
REQ-039 With the FIFO full, bench SHALL assert rd_en on the same edge as PUSH -> fifo_count stays 4, overflow stays 0.
REQ-040 Bench SHALL pulse reset low one cycle after a strobe -> no push, all outputs at reset values; the next good frame decodes normally.
